// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared register-file widths and write-back constants
//
// Purpose: common definitions for the write-back arbiter slice.
//   DATA_BUS      register data width
//   REG_ADDR_BUS  register address width
//   WB_Q_DEPTH    default pending-queue depth (power of two, >= 2)
//   WRITE_ENABLE / WRITE_DISABLE  register-file enable levels
package wb_arbiter_pkg;

  localparam int   DATA_BUS      = 32;
  localparam int   REG_ADDR_BUS  = 5;
  localparam int   WB_Q_DEPTH    = 4;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/wb_pending_queue.sv
// rtl/wb_pending_queue.sv - searchable circular queue of ALU results awaiting write-back
//
// Purpose: holds ALU results that lost arbitration, in program order.
// Ports:
//   clk, rst                      clock, async active-low reset
//   push, push_addr, push_data    enqueue at tail
//   pop                           drop head (caller guarantees non-empty)
//   squash_en, squash_addr        clear valid bit of every entry with that address
//   head_valid/addr/data          oldest entry
//   count                         occupied slots, squashed slots included
//   lookup_addr_*, hit_*, data_*  youngest valid match per lookup port
module wb_pending_queue
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = WB_Q_DEPTH,
  parameter int ADDR_W = REG_ADDR_BUS,
  parameter int DATA_W = DATA_BUS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     squash_en,
  input  logic [ADDR_W-1:0]        squash_addr,
  output logic                     head_valid,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [ADDR_W-1:0]        lookup_addr_1,
  input  logic [ADDR_W-1:0]        lookup_addr_2,
  output logic                     hit_1,
  output logic                     hit_2,
  output logic [DATA_W-1:0]        data_1,
  output logic [DATA_W-1:0]        data_2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // Squashed slots keep their place so that count and ordering are
      // unchanged; they just pop as empty write cycles.
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && vld_q[i] && (addr_q[i] == squash_addr)) begin
          vld_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      // The caller never pushes when full, so tail cannot collide with a
      // live head slot even when push and pop share a cycle.
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        addr_q[tail_q] <= push_addr;
        data_q[tail_q] <= push_data;
        tail_q         <= tail_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest.
  // Unoccupied slots always have their valid bit clear.
  function automatic logic [DATA_W:0] youngest(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0]  result;
    logic [PTR_W-1:0] idx;
    result = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (addr_q[idx] == addr) && (addr != '0)) begin
        result = {1'b1, data_q[idx]};
      end
    end
    return result;
  endfunction

  assign {hit_1, data_1} = youngest(lookup_addr_1);
  assign {hit_2, data_2} = youngest(lookup_addr_2);

  assign head_valid = vld_q[head_q];
  assign head_addr  = addr_q[head_q];
  assign head_data  = data_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges load-unit and ALU results onto the register-file write port
//
// Purpose: per-cycle priority load > queued ALU > bypassed ALU, registered output.
// Ports:
//   clk, rst                             clock, async active-low reset
//   alu_valid/ready/addr/data            back-pressurable ALU result stream
//   ld_valid/addr/data                   unstallable load result
//   write_en/addr/data                   registered register-file write
//   fwd_addr_*, fwd_hit_*, fwd_data_*    decode lookups into the pending queue
//   q_count                              pending-queue occupancy
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = WB_Q_DEPTH,
  parameter int ADDR_W = REG_ADDR_BUS,
  parameter int DATA_W = DATA_BUS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_addr,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    ld_valid,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    write_en,
  output logic [ADDR_W-1:0]       write_addr,
  output logic [DATA_W-1:0]       write_data,
  input  logic [ADDR_W-1:0]       fwd_addr_1,
  input  logic [ADDR_W-1:0]       fwd_addr_2,
  output logic                    fwd_hit_1,
  output logic                    fwd_hit_2,
  output logic [DATA_W-1:0]       fwd_data_1,
  output logic [DATA_W-1:0]       fwd_data_2,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              q_empty;
  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              ld_live;
  logic              alu_hs;
  logic              alu_keep;
  logic              take_pop;
  logic              take_byp;
  logic              push;

  assign q_empty   = (q_count == '0);
  // Occupancy is registered, so ready never depends on this cycle's inputs.
  assign alu_ready = (q_count < CNT_W'(DEPTH));

  // A load to r0 is discarded outright and does not claim the write slot.
  assign ld_live  = ld_valid && (ld_addr != '0);
  assign alu_hs   = alu_valid && alu_ready;
  // A same-cycle load to the same register is younger, so the ALU value is
  // dead on arrival; the handshake still completes.
  assign alu_keep = alu_hs && (alu_addr != '0) && !(ld_live && (ld_addr == alu_addr));
  assign take_pop = !ld_live && !q_empty;
  assign take_byp = !ld_live && q_empty && alu_hs;
  assign push     = alu_keep && !take_byp;

  wb_pending_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_addr     (alu_addr),
    .push_data     (alu_data),
    .pop           (take_pop),
    .squash_en     (ld_live),
    .squash_addr   (ld_addr),
    .head_valid    (head_valid),
    .head_addr     (head_addr),
    .head_data     (head_data),
    .count         (q_count),
    .lookup_addr_1 (fwd_addr_1),
    .lookup_addr_2 (fwd_addr_2),
    .hit_1         (fwd_hit_1),
    .hit_2         (fwd_hit_2),
    .data_1        (fwd_data_1),
    .data_2        (fwd_data_2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en   <= WRITE_DISABLE;
      write_addr <= '0;
      write_data <= '0;
    end else if (ld_live) begin
      write_en   <= WRITE_ENABLE;
      write_addr <= ld_addr;
      write_data <= ld_data;
    end else if (take_pop) begin
      // A squashed head still consumes its slot as an idle write cycle.
      write_en   <= head_valid ? WRITE_ENABLE : WRITE_DISABLE;
      write_addr <= head_addr;
      write_data <= head_data;
    end else if (take_byp) begin
      write_en   <= (alu_addr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
      write_addr <= alu_addr;
      write_data <= alu_data;
    end else begin
      write_en   <= WRITE_DISABLE;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              alu_valid = 1'b0;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_addr_1 = '0;
  logic [ADDR_W-1:0] fwd_addr_2 = '0;
  logic              fwd_hit_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_1;
  logic [DATA_W-1:0] fwd_data_2;
  logic [$clog2(DEPTH):0] q_count;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .fwd_addr_1 (fwd_addr_1),
    .fwd_addr_2 (fwd_addr_2),
    .fwd_hit_1  (fwd_hit_1),
    .fwd_hit_2  (fwd_hit_2),
    .fwd_data_1 (fwd_data_1),
    .fwd_data_2 (fwd_data_2),
    .q_count    (q_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit lv, input int la, input int ldd, input bit av,
                       input int aa, input int ad, input int f1, input int f2);
    ld_valid   = lv;
    ld_addr    = ADDR_W'(la);
    ld_data    = ldd;
    alu_valid  = av;
    alu_addr   = ADDR_W'(aa);
    alu_data   = ad;
    fwd_addr_1 = ADDR_W'(f1);
    fwd_addr_2 = ADDR_W'(f2);
  endtask

  // Directed vectors: inputs applied this cycle, expectations describe the
  // state visible in the same cycle (result of earlier rows).
  typedef struct {
    bit lv; int la; int ld; bit av; int aa; int ad; int f1; int f2;
    int cnt; bit rdy; bit we; int wa; int wd; bit h1; int d1; bit h2;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit lv, input int la, input int ld, input bit av, input int aa,
                     input int ad, input int f1, input int f2, input int cnt, input bit rdy,
                     input bit we, input int wa, input int wd, input bit h1, input int d1,
                     input bit h2);
    vec_t v;
    v.lv = lv; v.la = la; v.ld = ld; v.av = av; v.aa = aa; v.ad = ad; v.f1 = f1; v.f2 = f2;
    v.cnt = cnt; v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd; v.h1 = h1; v.d1 = d1; v.h2 = h2;
    tbl.push_back(v);
  endtask

  // Reference model: program-ordered list of pending results.
  typedef struct { int a; int d; bit v; } ent_t;
  ent_t mq[$];
  bit   m_we;
  int   m_wa;
  int   m_wd;

  function automatic void model_fwd(input int fa, output bit hit, output int data);
    hit  = 1'b0;
    data = 0;
    if (fa != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].v && mq[i].a == fa) begin
          hit  = 1'b1;
          data = mq[i].d;
          break;
        end
      end
    end
  endfunction

  function automatic void model_step(input bit lv, input int la, input int ldd,
                                     input bit av, input int aa, input int ad);
    bit   accepted;
    bit   load_real;
    ent_t e;
    accepted  = av && (mq.size() < DEPTH);
    load_real = lv && (la != 0);
    if (load_real) begin
      m_we = 1'b1; m_wa = la; m_wd = ldd;
      foreach (mq[i]) if (mq[i].a == la) mq[i].v = 1'b0;
      if (accepted && aa != 0 && aa != la) mq.push_back('{aa, ad, 1'b1});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = e.v; m_wa = e.a; m_wd = e.d;
      if (accepted && aa != 0) mq.push_back('{aa, ad, 1'b1});
    end else if (accepted) begin
      m_we = (aa != 0); m_wa = aa; m_wd = ad;
    end else begin
      m_we = 1'b0;
    end
  endfunction

  initial begin
    //  lv la  ld     av aa ad     f1 f2  cnt rdy we wa  wd     h1 d1   h2
    add(0, 0,  0,     1, 5, 'h11,  0, 0,  0,  1,  0, 0,  0,     0, 0,   0); // bypass
    add(1, 10, 'h100, 1, 1, 1,     0, 0,  0,  1,  1, 5,  'h11,  0, 0,   0); // load priority
    add(1, 11, 'h101, 1, 2, 2,     1, 0,  1,  1,  1, 10, 'h100, 1, 1,   0);
    add(1, 12, 'h102, 1, 3, 3,     2, 0,  2,  1,  1, 11, 'h101, 1, 2,   0);
    add(1, 13, 'h103, 1, 4, 4,     3, 4,  3,  1,  1, 12, 'h102, 1, 3,   0);
    add(0, 0,  0,     0, 0, 0,     4, 0,  4,  0,  1, 13, 'h103, 1, 4,   0);
    add(0, 0,  0,     0, 0, 0,     1, 0,  3,  1,  1, 1,  1,     0, 0,   0);
    add(0, 0,  0,     0, 0, 0,     4, 0,  2,  1,  1, 2,  2,     1, 4,   0);
    add(0, 0,  0,     0, 0, 0,     0, 0,  1,  1,  1, 3,  3,     0, 0,   0);
    add(1, 20, 'h200, 1, 7, 'hA,   0, 0,  0,  1,  1, 4,  4,     0, 0,   0); // squash
    add(1, 7,  'hB,   0, 0, 0,     7, 0,  1,  1,  1, 20, 'h200, 1, 'hA, 0);
    add(0, 0,  0,     0, 0, 0,     7, 0,  1,  1,  1, 7,  'hB,   0, 0,   0);
    add(0, 0,  0,     0, 0, 0,     0, 0,  0,  1,  0, 0,  0,     0, 0,   0);
    add(1, 21, 'h210, 1, 9, 1,     9, 0,  0,  1,  0, 0,  0,     0, 0,   0); // forwarding
    add(1, 22, 'h220, 1, 9, 2,     9, 0,  1,  1,  1, 21, 'h210, 1, 1,   0);
    add(1, 23, 'h230, 1, 0, 5,     9, 0,  2,  1,  1, 22, 'h220, 1, 2,   0);
    add(0, 0,  0,     0, 0, 0,     9, 0,  2,  1,  1, 23, 'h230, 1, 2,   0);
    add(0, 0,  0,     0, 0, 0,     9, 0,  1,  1,  1, 9,  1,     1, 2,   0);
    add(1, 0,  'h77,  1, 0, 'h66,  0, 0,  0,  1,  1, 9,  2,     0, 0,   0); // zero register
    add(1, 0,  'h78,  1, 0, 'h67,  0, 0,  0,  1,  0, 0,  0,     0, 0,   0);
    add(0, 0,  0,     0, 0, 0,     0, 0,  0,  1,  0, 0,  0,     0, 0,   0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_write_en", 32'(write_en), 0);
    chk("reset_write_addr", 32'(write_addr), 0);
    chk("reset_write_data", write_data, 0);
    chk("reset_q_count", 32'(q_count), 0);
    chk("reset_fwd_hit_1", 32'(fwd_hit_1), 0);
    chk("reset_fwd_hit_2", 32'(fwd_hit_2), 0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].f1, tbl[i].f2);
      #1;
      chk($sformatf("row%0d_q_count", i), 32'(q_count), tbl[i].cnt);
      chk($sformatf("row%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_write_en", i), 32'(write_en), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("row%0d_write_addr", i), 32'(write_addr), tbl[i].wa);
        chk($sformatf("row%0d_write_data", i), write_data, tbl[i].wd);
      end
      chk($sformatf("row%0d_fwd_hit_1", i), 32'(fwd_hit_1), 32'(tbl[i].h1));
      if (tbl[i].h1) chk($sformatf("row%0d_fwd_data_1", i), fwd_data_1, tbl[i].d1);
      chk($sformatf("row%0d_fwd_hit_2", i), 32'(fwd_hit_2), 32'(tbl[i].h2));
    end

    // Reset mid-stream with three entries queued
    @(negedge clk); drive(1, 10, 'h100, 1, 1, 'h51, 1, 0);
    @(negedge clk); drive(1, 11, 'h101, 1, 2, 'h52, 1, 0);
    @(negedge clk); drive(1, 12, 'h102, 1, 3, 'h53, 1, 0);
    @(negedge clk); drive(1, 13, 'h103, 0, 0, 0, 1, 0);
    #1;
    chk("midrst_q_count_before", 32'(q_count), 3);
    chk("midrst_fwd_hit_before", 32'(fwd_hit_1), 1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_write_en", 32'(write_en), 0);
    chk("midrst_write_addr", 32'(write_addr), 0);
    chk("midrst_write_data", write_data, 0);
    chk("midrst_q_count", 32'(q_count), 0);
    chk("midrst_fwd_hit", 32'(fwd_hit_1), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("postrst%0d_write_en", i), 32'(write_en), 0);
      chk($sformatf("postrst%0d_q_count", i), 32'(q_count), 0);
      chk($sformatf("postrst%0d_alu_ready", i), 32'(alu_ready), 1);
    end

    // Randomized traffic against the reference model
    mq.delete();
    m_we = 1'b0; m_wa = 0; m_wd = 0;
    for (int n = 0; n < 600; n++) begin
      bit lv, av, h;
      int la, ldd, aa, ad, f1, f2, d;
      @(negedge clk);
      chk("rnd_write_en", 32'(write_en), 32'(m_we));
      if (m_we) begin
        chk("rnd_write_addr", 32'(write_addr), m_wa);
        chk("rnd_write_data", write_data, m_wd);
      end
      chk("rnd_q_count", 32'(q_count), mq.size());
      chk("rnd_alu_ready", 32'(alu_ready), 32'(mq.size() < DEPTH));
      lv  = ($urandom_range(0, 2) == 0);
      la  = $urandom_range(0, 7);
      ldd = $urandom();
      av  = ($urandom_range(0, 3) != 0);
      aa  = $urandom_range(0, 7);
      ad  = $urandom();
      f1  = $urandom_range(0, 7);
      f2  = $urandom_range(0, 7);
      drive(lv, la, ldd, av, aa, ad, f1, f2);
      #1;
      model_fwd(f1, h, d);
      chk("rnd_fwd_hit_1", 32'(fwd_hit_1), 32'(h));
      if (h) chk("rnd_fwd_data_1", fwd_data_1, d);
      model_fwd(f2, h, d);
      chk("rnd_fwd_hit_2", 32'(fwd_hit_2), 32'(h));
      if (h) chk("rnd_fwd_data_2", fwd_data_2, d);
      model_step(lv, la, ldd, av, aa, ad);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
